// File: rtl/audio_pkg.sv
// Shared constants, state type and melody ROM for the audio event sequencer.
// Note values are tone-generator prescalers for a 25 MHz clock.
package audio_pkg;

  localparam logic [9:0] DO   = 10'h175;
  localparam logic [9:0] RE   = 10'h14C;
  localparam logic [9:0] MI   = 10'h128;
  localparam logic [9:0] FA   = 10'h117;
  localparam logic [9:0] SOL  = 10'h0F9;
  localparam logic [9:0] LA   = 10'h0DD;
  localparam logic [9:0] SI   = 10'h0C5;
  localparam logic [9:0] REST = 10'h000;

  localparam int EV_ENTER  = 0;
  localparam int EV_HOLE   = 1;
  localparam int EV_BORDER = 2;
  localparam int EV_BALL   = 3;
  localparam int EV_KEYX   = 4;
  localparam int EV_KEYY   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int ROM_EVENTS = 6;
  localparam int ROM_NOTES  = 4;

  localparam logic [9:0] MELODY_ROM [ROM_EVENTS*ROM_NOTES] = '{
    DO,   MI,   SOL,  REST,
    LA,   FA,   RE,   REST,
    SI,   REST, REST, REST,
    FA,   REST, REST, REST,
    RE,   REST, REST, REST,
    MI,   REST, REST, REST
  };

  // Out-of-range events or note slots read as REST, which ends a melody.
  function automatic logic [9:0] melodyNote(input int ev, input int idx);
    if (ev < 0 || ev >= ROM_EVENTS || idx < 0 || idx >= ROM_NOTES)
      return REST;
    return MELODY_ROM[5'(ev * ROM_NOTES + idx)];
  endfunction

endpackage

// File: rtl/audio_priority_encoder.sv
// Lowest-index-wins priority encoder.
// Produces a valid flag and the index of the lowest set request bit.
module audio_priority_encoder #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/audio_event_sequencer.sv
// Latches sound requests, arbitrates by fixed priority and plays a
// per-event melody of timed notes separated by silent gaps.
module audio_event_sequencer
  import audio_pkg::*;
#(
  parameter int NUM_EVENTS = 6,
  parameter int PRESCALE_W = 10,
  parameter int MAX_NOTES  = 4,
  parameter int NOTE_TICKS = 2_500_000,
  parameter int GAP_TICKS  = 250_000,
  parameter int PREEMPT    = 1
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_EVENTS-1:0]         soundRequest,
  output logic [PRESCALE_W-1:0]         preScaleValue,
  output logic                          enableSound,
  output logic                          busy,
  output logic [$clog2(NUM_EVENTS)-1:0] activeEvent,
  output logic [NUM_EVENTS-1:0]         pendingMask
);

  localparam int EW   = $clog2(NUM_EVENTS);
  localparam int NW   = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam int TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int GAPL = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  state_t                state;
  logic [NUM_EVENTS-1:0] pending;
  logic [NUM_EVENTS-1:0] cand;
  logic [NUM_EVENTS-1:0] grantMask;
  logic                  winValid;
  logic [EW-1:0]         winIdx;
  logic [NW-1:0]         noteIdx;
  logic [CW-1:0]         counter;
  logic                  grant;
  logic                  lastNote;
  logic [PRESCALE_W-1:0] firstNote;
  logic [PRESCALE_W-1:0] nextNote;

  audio_priority_encoder #(
    .N  (NUM_EVENTS),
    .IW (EW)
  ) uEnc (
    .req   (cand),
    .valid (winValid),
    .idx   (winIdx)
  );

  always_comb begin
    cand      = pending | soundRequest;
    firstNote = PRESCALE_W'(melodyNote(int'(winIdx), 0));
    nextNote  = PRESCALE_W'(melodyNote(int'(activeEvent), int'(noteIdx) + 1));
    lastNote  = (int'(noteIdx) == MAX_NOTES - 1) || (nextNote == '0);
    grant     = winValid &&
                ((state == IDLE) || ((PREEMPT != 0) && (winIdx < activeEvent)));
    grantMask = grant ? (NUM_EVENTS'(1) << winIdx) : '0;
  end

  assign busy        = (state != IDLE);
  assign pendingMask = pending;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      pending       <= '0;
      noteIdx       <= '0;
      counter       <= '0;
      preScaleValue <= '0;
      enableSound   <= 1'b0;
      activeEvent   <= '0;
    end else begin
      pending <= cand & ~grantMask;
      if (grant) begin
        // A grant always restarts at note 0; preempted melodies are dropped.
        activeEvent <= winIdx;
        noteIdx     <= '0;
        counter     <= CW'(NOTE_TICKS - 1);
        if (firstNote != '0) begin
          state         <= PLAY;
          preScaleValue <= firstNote;
          enableSound   <= 1'b1;
        end else begin
          state         <= IDLE;
          preScaleValue <= '0;
          enableSound   <= 1'b0;
        end
      end else begin
        unique case (state)
          PLAY: begin
            if (counter != '0) begin
              counter <= counter - 1'b1;
            end else if (lastNote) begin
              state         <= IDLE;
              preScaleValue <= '0;
              enableSound   <= 1'b0;
            end else if (GAP_TICKS == 0) begin
              noteIdx       <= noteIdx + 1'b1;
              counter       <= CW'(NOTE_TICKS - 1);
              preScaleValue <= nextNote;
            end else begin
              state         <= GAP;
              counter       <= CW'(GAPL);
              preScaleValue <= '0;
              enableSound   <= 1'b0;
            end
          end
          GAP: begin
            if (counter != '0) begin
              counter <= counter - 1'b1;
            end else begin
              state         <= PLAY;
              noteIdx       <= noteIdx + 1'b1;
              counter       <= CW'(NOTE_TICKS - 1);
              preScaleValue <= nextNote;
              enableSound   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
